// File: rtl/alu_ctrl_if.sv
// Instruction handshake between issuer and alu_ctrl.
// Master offers instr/instr_valid; slave returns instr_ready.
interface alu_ctrl_if;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/alu_ctrl.sv
// Four-phase controller sequencing an external ALU over
// an 8-entry register file: IDLE -> READ -> EXEC -> WB.
module alu_ctrl #(
  parameter int W   = 8,
  parameter int Ops = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_ctrl_if.slave      cpu,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [Ops-1:0] alu_op,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_sign,
  input  logic           reg_wr_en,
  input  logic [2:0]     reg_wr_addr,
  input  logic [W-1:0]   reg_wr_data,
  input  logic [2:0]     dbg_addr,
  output logic [W-1:0]   dbg_data,
  output logic [W-1:0]   result,
  output logic           zero_flag,
  output logic           sign_flag,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  state_t         r_state;
  state_t         w_nxt;

  logic [8:0]     r_ir;
  logic [W-1:0]   r_rf [8];
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [Ops-1:0] r_op;
  logic [W-1:0]   r_res;
  logic           r_zf;
  logic           r_sf;

  logic [2:0]     w_opc;
  logic [2:0]     w_rd;
  logic [2:0]     w_rs;
  logic           w_alu;
  logic           w_clr;
  logic           w_ill;

  logic           w_ready;
  logic           w_acc;
  logic           w_ld;
  logic           w_cap;
  logic           w_wb;
  logic           w_done;
  logic           w_err;

  assign w_opc = r_ir[8:6];
  assign w_rd  = r_ir[5:3];
  assign w_rs  = r_ir[2:0];

  // 0xx goes to the ALU, 100 clears, 101..111 are illegal
  assign w_alu = ~w_opc[2];
  assign w_clr = (w_opc == 3'b100);
  assign w_ill = w_opc[2] & (|w_opc[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_ready = 1'b0;
    w_acc   = 1'b0;
    w_ld    = 1'b0;
    w_cap   = 1'b0;
    w_wb    = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cpu.instr_valid) begin
          w_acc = 1'b1;
          w_nxt = S_READ;
        end
      end
      S_READ: begin
        w_ld  = w_alu;
        w_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_cap = 1'b1;
        w_nxt = S_WB;
      end
      S_WB: begin
        w_done = 1'b1;
        w_err  = w_ill;
        w_wb   = ~w_ill;
        w_nxt  = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (w_acc) begin
      r_ir <= cpu.instr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_ld) begin
      r_a  <= r_rf[w_rd];
      r_b  <= r_rf[w_rs];
      r_op <= Ops'(w_opc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_zf  <= 1'b0;
      r_sf  <= 1'b0;
    end else if (w_cap) begin
      unique case (1'b1)
        w_alu: begin
          r_res <= alu_out;
          r_zf  <= alu_zero;
          r_sf  <= alu_sign;
        end
        w_clr: begin
          r_res <= '0;
          r_zf  <= 1'b1;
          r_sf  <= 1'b0;
        end
        default: begin
          r_res <= r_res;
        end
      endcase
    end
  end

  // writeback beats the external port on an address clash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_wb && (w_rd == 3'(i))) begin
          r_rf[i] <= r_res;
        end else if (reg_wr_en && (reg_wr_addr == 3'(i))) begin
          r_rf[i] <= reg_wr_data;
        end
      end
    end
  end

  assign cpu.instr_ready = w_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign dbg_data  = r_rf[dbg_addr];
  assign result    = r_res;
  assign zero_flag = r_zf;
  assign sign_flag = r_sf;
  assign done      = w_done;
  assign err       = w_err;

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter W, default 8, datapath and register width.
REQ-002 Parameter Ops, default 3, ALU opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr  input  9  [8:6] opcode, [5:3] rd, [2:0] rs.
REQ-007 instr_ready  output  1  controller can accept an instruction.
REQ-008 alu_a / alu_b  output  W each  registered ALU operands.
REQ-009 alu_op  output  Ops  registered ALU opcode.
REQ-010 alu_out  input  W  combinational ALU result.
REQ-011 alu_zero / alu_sign  input  1 each  ALU flags.
REQ-012 reg_wr_en, reg_wr_addr[2:0], reg_wr_data[W-1:0]  input  external register load port.
REQ-013 dbg_addr  input  3; dbg_data  output  W  combinational read of R[dbg_addr].
REQ-014 result  output  W  last committed result.
REQ-015 zero_flag / sign_flag  output  1 each  last committed flags.
REQ-016 done / err  output  1 each  one-cycle completion / illegal-opcode pulses.

Function
REQ-017 Internal register file R0..R7, W bits each.
REQ-018 FSM states IDLE, READ, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: instr_valid && instr_ready captures instr into an internal instruction register; next state READ; otherwise stay IDLE.
REQ-020 READ: load alu_a=R[rd], alu_b=R[rs], alu_op=opcode (opcodes 000-011 only); next state EXEC.
REQ-021 Opcodes: 000 ADD, 001 SHR, 010 SHL, 011 XOR pass to ALU; 100 CLR; 101-111 illegal.
REQ-022 EXEC: ALU ops capture alu_out, alu_zero, alu_sign into result, zero_flag, sign_flag; CLR loads result=0, zero_flag=1, sign_flag=0; illegal leaves result and flags unchanged; next state WB.
REQ-023 WB: legal op writes R[rd]=result and asserts done for exactly this cycle; illegal op asserts done and err, no register write; next state IDLE.
REQ-024 Latency: accept edge at cycle N -> done high in cycle N+3 -> instr_ready high in cycle N+4; at most one instruction every 4 cycles.
REQ-025 alu_a, alu_b, alu_op SHALL hold their values outside READ-load edges; they are not updated for CLR or illegal opcodes.
REQ-026 External write SHALL take effect on the next edge in any state; simultaneous WB write to the same address SHALL win over the external write; different addresses both commit.
REQ-027 External write to R[rd] or R[rs] during EXEC/WB does not affect the in-flight operation (operands already registered in READ).
REQ-028 rd == rs SHALL be legal (e.g. XOR R3,R3 yields 0).
REQ-029 Arithmetic wraps modulo 2^W; the controller does no width extension.
REQ-030 instr_valid while not ready SHALL be ignored with no state change.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, R0..R7=0, alu_a=alu_b=0, alu_op=0, result=0, zero_flag=sign_flag=0, done=err=0; instr_ready=1 while in reset.
REQ-032 Reset mid-operation SHALL abort with no register write and no done pulse.
REQ-033 First accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 Load R1=0x0F, R2=0x01; ADD rd=1 rs=2 with bench ALU model -> alu_a=0x0F, alu_b=0x01, alu_op=000 in EXEC; done at N+3; R1=0x10, zero_flag=0.
REQ-035 Load R4=0xFF, R5=0x01; ADD rd=4 rs=5 -> R4=0x00, zero_flag=1, result=0x00.
REQ-036 XOR rd=3 rs=3 with R3=0xA5 -> R3=0x00; then CLR rd=6 with R6=0x55 -> R6=0x00, zero_flag=1, sign_flag=0, alu_op still 011.
REQ-037 Opcode 110 -> done and err high together in N+3 for one cycle; registers, result, flags unchanged; instr_valid held during busy cycles accepted only at N+4.
REQ-038 In WB of ADD rd=2, external write R2=0x77 same edge -> R2 holds ALU result; repeat with reg_wr_addr=7 -> R7=0x77 and R2 updated.
REQ-039 Assert rst_n low during EXEC -> no done, all outputs and R0..R7 read 0 via dbg_data, instr_ready=1.
